// File: rtl/mem_transmitter_pkg.sv
// Shared constants, state/command encodings and write-pattern helper for the
// memory-test transmitter.
package mem_transmitter_pkg;

   localparam int unsigned AMM_ADDR_W  = 31;
   localparam int unsigned AMM_DATA_W  = 128;
   localparam int unsigned AMM_BURST_W = 11;
   localparam int unsigned MAX_PENDING = 1024;
   localparam int unsigned WORD_W      = 32;

   typedef enum logic [1:0] {
      IDLE_S  = 2'd0,
      WRITE_S = 2'd1,
      READ_S  = 2'd2
   } trans_state_t;

   typedef enum logic {
      TRANS_WRITE = 1'b0,
      TRANS_READ  = 1'b1
   } trans_type_t;

   // Deterministic write word: seed plus running word index, wrapping at 2^32.
   function automatic logic [WORD_W-1:0] pattern_word(input logic [WORD_W-1:0] seed,
                                                      input logic [WORD_W-1:0] idx);
      return seed + idx;
   endfunction

endpackage

// File: rtl/mem_transmitter_if.sv
// Avalon-MM master/slave bus between the transmitter and the memory under test.
interface mem_transmitter_if #(
   parameter int unsigned ADDR_W  = mem_transmitter_pkg::AMM_ADDR_W,
   parameter int unsigned DATA_W  = mem_transmitter_pkg::AMM_DATA_W,
   parameter int unsigned BURST_W = mem_transmitter_pkg::AMM_BURST_W
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic [ADDR_W-1:0]  address;
   logic               read;
   logic               write;
   logic [DATA_W-1:0]  writedata;
   logic [BE_W-1:0]    byteenable;
   logic [BURST_W-1:0] burstcount;
   logic               waitrequest;
   logic               readdatavalid;

   modport master (
      output address, read, write, writedata, byteenable, burstcount,
      input  waitrequest, readdatavalid
   );

   modport slave (
      input  address, read, write, writedata, byteenable, burstcount,
      output waitrequest, readdatavalid
   );

endinterface

// File: rtl/mem_transmitter_rd_pending_cnt.sv
// Counts read beats still owed by memory, flags when another burst would exceed
// the outstanding limit, and records stray readdatavalid pulses.
module mem_transmitter_rd_pending_cnt #(
   parameter int unsigned BURST_W     = mem_transmitter_pkg::AMM_BURST_W,
   parameter int unsigned MAX_PENDING = mem_transmitter_pkg::MAX_PENDING
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               clr_i,
   input  logic               inc_i,
   input  logic [BURST_W-1:0] burst_len_i,
   input  logic               dec_i,
   output logic               rd_stall_c,
   output logic               pend_nz_c,
   output logic               rd_underflow_o
);

   localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
   localparam int unsigned SUM_W  = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

   logic [PEND_W-1:0] pending;
   logic [SUM_W-1:0]  sum_c;
   logic              underflow_c;

   assign sum_c       = SUM_W'(pending) + SUM_W'(burst_len_i);
   assign rd_stall_c  = sum_c > SUM_W'(MAX_PENDING);
   assign pend_nz_c   = pending != '0;
   assign underflow_c = dec_i && !inc_i && !pend_nz_c;

   // The stall guard on accept keeps pending + burst_len within range on increment.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pending        <= '0;
         rd_underflow_o <= 1'b0;
      end else begin
         if (inc_i) begin
            pending <= PEND_W'(sum_c - SUM_W'(dec_i));
         end else if (dec_i && pend_nz_c) begin
            pending <= pending - PEND_W'(1);
         end

         if (underflow_c) begin
            rd_underflow_o <= 1'b1;
         end else if (clr_i) begin
            rd_underflow_o <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_transmitter.sv
// Executes controller write/read commands as Avalon-MM bursts with a seeded
// incrementing write pattern and tracks outstanding read beats.
module mem_transmitter #(
   parameter int unsigned AMM_ADDR_W  = mem_transmitter_pkg::AMM_ADDR_W,
   parameter int unsigned AMM_DATA_W  = mem_transmitter_pkg::AMM_DATA_W,
   parameter int unsigned AMM_BURST_W = mem_transmitter_pkg::AMM_BURST_W,
   parameter int unsigned MAX_PENDING = mem_transmitter_pkg::MAX_PENDING
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_test_i,
   input  logic [AMM_BURST_W-1:0] burstcount_i,
   input  logic [31:0]            data_seed_i,
   input  logic                   trans_valid_i,
   input  logic                   trans_type_i,
   input  logic [AMM_ADDR_W-1:0]  trans_addr_i,
   output logic                   trans_process_o,
   output logic                   trans_busy_o,
   output logic                   rd_underflow_o,
   mem_transmitter_if.master      amm
);

   import mem_transmitter_pkg::*;

   localparam int unsigned WORDS = AMM_DATA_W / WORD_W;

   trans_state_t           state;
   logic [AMM_BURST_W-1:0] burst_len;
   logic [AMM_BURST_W-1:0] beat_idx;
   logic [WORD_W-1:0]      seed;
   logic [WORD_W-1:0]      wr_word_cnt;
   logic [AMM_ADDR_W-1:0]  address;
   logic [AMM_BURST_W-1:0] burstcount;
   logic [AMM_DATA_W-1:0]  writedata;
   logic                   read_q;
   logic                   write_q;
   logic                   busy_q;

   logic                   start_ok;
   logic                   rd_inc;
   logic                   rd_stall;
   logic                   pend_nz;
   logic [AMM_BURST_W-1:0] len_nx;
   logic [WORD_W-1:0]      seed_nx;
   logic [WORD_W-1:0]      cnt_nx;

   assign start_ok        = start_test_i && (state == IDLE_S);
   assign rd_inc          = (state == READ_S) && !amm.waitrequest;
   assign trans_process_o = (state != IDLE_S) || rd_stall;

   // Test settings as seen by a command accepted in the same cycle as start.
   always_comb begin
      len_nx  = burst_len;
      seed_nx = seed;
      cnt_nx  = wr_word_cnt;
      if (start_ok) begin
         len_nx  = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
         seed_nx = data_seed_i;
         cnt_nx  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= IDLE_S;
         burst_len   <= AMM_BURST_W'(1);
         beat_idx    <= '0;
         seed        <= '0;
         wr_word_cnt <= '0;
         address     <= '0;
         burstcount  <= '0;
         writedata   <= '0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         busy_q <= (state != IDLE_S) || pend_nz;
         unique case (state)
            IDLE_S: begin
               burst_len   <= len_nx;
               seed        <= seed_nx;
               wr_word_cnt <= cnt_nx;
               if (trans_valid_i && !rd_stall) begin
                  address    <= trans_addr_i;
                  burstcount <= len_nx;
                  beat_idx   <= '0;
                  if (trans_type_t'(trans_type_i) == TRANS_READ) begin
                     read_q <= 1'b1;
                     state  <= READ_S;
                  end else begin
                     write_q   <= 1'b1;
                     writedata <= {WORDS{pattern_word(seed_nx, cnt_nx)}};
                     state     <= WRITE_S;
                  end
               end
            end
            WRITE_S: begin
               // Data for the following beat is prepared as each beat is taken.
               if (!amm.waitrequest) begin
                  wr_word_cnt <= wr_word_cnt + 32'd1;
                  writedata   <= {WORDS{pattern_word(seed, wr_word_cnt + 32'd1)}};
                  if (beat_idx == burstcount - AMM_BURST_W'(1)) begin
                     write_q  <= 1'b0;
                     beat_idx <= '0;
                     state    <= IDLE_S;
                  end else begin
                     beat_idx <= beat_idx + AMM_BURST_W'(1);
                  end
               end
            end
            READ_S: begin
               if (!amm.waitrequest) begin
                  read_q <= 1'b0;
                  state  <= IDLE_S;
               end
            end
            default: state <= IDLE_S;
         endcase
      end
   end

   mem_transmitter_rd_pending_cnt #(
      .BURST_W     (AMM_BURST_W),
      .MAX_PENDING (MAX_PENDING)
   ) u_rd_pending_cnt (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .clr_i          (start_ok),
      .inc_i          (rd_inc),
      .burst_len_i    (burst_len),
      .dec_i          (amm.readdatavalid),
      .rd_stall_c     (rd_stall),
      .pend_nz_c      (pend_nz),
      .rd_underflow_o (rd_underflow_o)
   );

   assign trans_busy_o   = busy_q;
   assign amm.address    = address;
   assign amm.read       = read_q;
   assign amm.write      = write_q;
   assign amm.writedata  = writedata;
   assign amm.byteenable = '1;
   assign amm.burstcount = burstcount;

endmodule

// File: tb/tb_mem_transmitter.sv
// Bench for mem_transmitter: directed vector table, hand-written corner cases and
// random traffic checked against a transaction-level reference model.
module tb_mem_transmitter;

   localparam int unsigned MAXP = 16;

   logic        clk;
   logic        rst_n;
   logic        start_test;
   logic [10:0] burstcount;
   logic [31:0] data_seed;
   logic        trans_valid;
   logic        trans_type;
   logic [30:0] trans_addr;
   logic        trans_process;
   logic        trans_busy;
   logic        rd_underflow;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit          m_active;
   bit          m_is_rd;
   logic [30:0] m_addr;
   int unsigned m_cmd_len;
   int unsigned m_beat;
   int unsigned m_len;
   int unsigned m_pend;
   logic [31:0] m_seed;
   logic [31:0] m_cnt;
   bit          m_uf;
   bit          m_busy;

   mem_transmitter_if #(.ADDR_W(31), .DATA_W(128), .BURST_W(11)) amm_if ();

   mem_transmitter #(
      .AMM_ADDR_W  (31),
      .AMM_DATA_W  (128),
      .AMM_BURST_W (11),
      .MAX_PENDING (MAXP)
   ) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .start_test_i    (start_test),
      .burstcount_i    (burstcount),
      .data_seed_i     (data_seed),
      .trans_valid_i   (trans_valid),
      .trans_type_i    (trans_type),
      .trans_addr_i    (trans_addr),
      .trans_process_o (trans_process),
      .trans_busy_o    (trans_busy),
      .rd_underflow_o  (rd_underflow),
      .amm             (amm_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] rep(input logic [31:0] w);
      return {4{w}};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_is_rd = 1'b0; m_addr = '0; m_cmd_len = 0; m_beat = 0;
      m_len = 1; m_pend = 0; m_seed = '0; m_cnt = '0; m_uf = 1'b0; m_busy = 1'b0;
   endtask

   // Expected outputs for the current cycle, derived from the model.
   task automatic check_model();
      chk("m.write", 128'(amm_if.write), 128'(m_active && !m_is_rd));
      chk("m.read", 128'(amm_if.read), 128'(m_active && m_is_rd));
      chk("m.process", 128'(trans_process), 128'(m_active || (m_pend + m_len > MAXP)));
      chk("m.busy", 128'(trans_busy), 128'(m_busy));
      chk("m.underflow", 128'(rd_underflow), 128'(m_uf));
      if (m_active) begin
         chk("m.address", 128'(amm_if.address), 128'(m_addr));
         chk("m.burstcount", 128'(amm_if.burstcount), 128'(m_cmd_len));
         if (!m_is_rd) chk("m.writedata", amm_if.writedata, rep(m_seed + m_cnt));
      end
   endtask

   // Advance the model across one clock edge given the inputs held during the cycle.
   task automatic model_step(input logic st, input logic [10:0] bc, input logic [31:0] sd,
                             input logic v, input logic ty, input logic [30:0] ad,
                             input logic wt, input logic dv);
      bit proc, busy_nx, inc, uf_set;
      proc    = m_active || (m_pend + m_len > MAXP);
      busy_nx = m_active || (m_pend != 0);
      inc     = m_active && m_is_rd && !wt;
      uf_set  = 1'b0;
      if (inc) m_pend = m_pend + m_cmd_len - (dv ? 1 : 0);
      else if (dv) begin
         if (m_pend > 0) m_pend = m_pend - 1;
         else uf_set = 1'b1;
      end
      if (uf_set) m_uf = 1'b1;
      else if (st && !m_active) m_uf = 1'b0;
      if (m_active) begin
         if (!wt) begin
            if (m_is_rd) m_active = 1'b0;
            else begin
               m_cnt  = m_cnt + 32'd1;
               m_beat = m_beat + 1;
               if (m_beat == m_cmd_len) m_active = 1'b0;
            end
         end
      end else begin
         if (st) begin
            m_len  = (bc == 11'd0) ? 1 : int'(bc);
            m_seed = sd;
            m_cnt  = '0;
         end
         if (v && !proc) begin
            m_active = 1'b1; m_is_rd = ty; m_addr = ad; m_cmd_len = m_len; m_beat = 0;
         end
      end
      m_busy = busy_nx;
   endtask

   task automatic cycle(input logic st, input logic [10:0] bc, input logic [31:0] sd,
                        input logic v, input logic ty, input logic [30:0] ad,
                        input logic wt, input logic dv);
      check_model();
      start_test = st; burstcount = bc; data_seed = sd;
      trans_valid = v; trans_type = ty; trans_addr = ad;
      amm_if.waitrequest = wt; amm_if.readdatavalid = dv;
      model_step(st, bc, sd, v, ty, ad, wt, dv);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      check_model();
      rst_n = 1'b0; start_test = 1'b0; trans_valid = 1'b0;
      amm_if.waitrequest = 1'b0; amm_if.readdatavalid = 1'b0;
      @(posedge clk); #1;
      model_reset();
      rst_n = 1'b1;
   endtask

   // Return every owed read beat; a bounded loop so a stuck design still ends.
   task automatic drain();
      for (int i = 0; i < 64 && (m_pend != 0 || m_active || trans_busy); i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, logic'(m_pend != 0));
      chk("drain_busy", 128'(trans_busy), 128'(1'b0));
   endtask

   typedef struct {
      logic        st;
      logic [10:0] bc;
      logic [31:0] sd;
      logic        v;
      logic [30:0] ad;
      logic        wt;
      logic        e_wr;
      logic        e_proc;
      logic        e_busy;
      logic [31:0] e_word;
      logic [30:0] e_addr;
      logic [10:0] e_bc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic st, input logic [10:0] bc, input logic [31:0] sd,
                                input logic v, input logic [30:0] ad, input logic wt,
                                input logic e_wr, input logic e_proc, input logic e_busy,
                                input logic [31:0] e_word, input logic [30:0] e_addr,
                                input logic [10:0] e_bc);
      vec_t r;
      r.st = st; r.bc = bc; r.sd = sd; r.v = v; r.ad = ad; r.wt = wt;
      r.e_wr = e_wr; r.e_proc = e_proc; r.e_busy = e_busy;
      r.e_word = e_word; r.e_addr = e_addr; r.e_bc = e_bc;
      return r;
   endfunction

   initial begin
      // Write burst 4, seed 0x1000_0000, no stalls (expected = state after each edge)
      vecs.push_back(mkv(1, 4, 32'h1000_0000, 0, '0,    0, 0, 0, 0, '0,           '0,    '0));
      vecs.push_back(mkv(0, 0, '0,            1, 31'h40, 0, 1, 1, 0, 32'h1000_0000, 31'h40, 4));
      vecs.push_back(mkv(0, 0, '0,            0, '0,    0, 1, 1, 1, 32'h1000_0001, 31'h40, 4));
      vecs.push_back(mkv(0, 0, '0,            0, '0,    0, 1, 1, 1, 32'h1000_0002, 31'h40, 4));
      vecs.push_back(mkv(0, 0, '0,            0, '0,    0, 1, 1, 1, 32'h1000_0003, 31'h40, 4));
      vecs.push_back(mkv(0, 0, '0,            0, '0,    0, 0, 0, 1, '0,           '0,    '0));
      vecs.push_back(mkv(0, 0, '0,            0, '0,    0, 0, 0, 0, '0,           '0,    '0));
      // Write burst 2 with three stalled cycles on the first beat
      vecs.push_back(mkv(1, 2, 32'hA5A5_0000, 0, '0,     0, 0, 0, 0, '0,           '0,     '0));
      vecs.push_back(mkv(0, 0, '0,            1, 31'h200, 0, 1, 1, 0, 32'hA5A5_0000, 31'h200, 2));
      vecs.push_back(mkv(0, 0, '0,            0, '0,     1, 1, 1, 1, 32'hA5A5_0000, 31'h200, 2));
      vecs.push_back(mkv(0, 0, '0,            0, '0,     1, 1, 1, 1, 32'hA5A5_0000, 31'h200, 2));
      vecs.push_back(mkv(0, 0, '0,            0, '0,     1, 1, 1, 1, 32'hA5A5_0000, 31'h200, 2));
      vecs.push_back(mkv(0, 0, '0,            0, '0,     0, 1, 1, 1, 32'hA5A5_0001, 31'h200, 2));
      vecs.push_back(mkv(0, 0, '0,            0, '0,     0, 0, 0, 1, '0,           '0,     '0));
      vecs.push_back(mkv(0, 0, '0,            0, '0,     0, 0, 0, 0, '0,           '0,     '0));

      rst_n = 1'b0; start_test = 1'b0; burstcount = '0; data_seed = '0;
      trans_valid = 1'b0; trans_type = 1'b0; trans_addr = '0;
      amm_if.waitrequest = 1'b0; amm_if.readdatavalid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.write", 128'(amm_if.write), 128'(1'b0));
      chk("rst.read", 128'(amm_if.read), 128'(1'b0));
      chk("rst.address", 128'(amm_if.address), 128'(1'b0));
      chk("rst.writedata", amm_if.writedata, 128'(1'b0));
      chk("rst.busy", 128'(trans_busy), 128'(1'b0));
      chk("rst.underflow", 128'(rd_underflow), 128'(1'b0));
      chk("rst.process", 128'(trans_process), 128'(1'b0));
      chk("byteenable", 128'(amm_if.byteenable), 128'(16'hFFFF));
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         cycle(vecs[i].st, vecs[i].bc, vecs[i].sd, vecs[i].v, 1'b0, vecs[i].ad, vecs[i].wt, 1'b0);
         chk($sformatf("vec%0d.write", i), 128'(amm_if.write), 128'(vecs[i].e_wr));
         chk($sformatf("vec%0d.process", i), 128'(trans_process), 128'(vecs[i].e_proc));
         chk($sformatf("vec%0d.busy", i), 128'(trans_busy), 128'(vecs[i].e_busy));
         if (vecs[i].e_wr) begin
            chk($sformatf("vec%0d.data", i), amm_if.writedata, rep(vecs[i].e_word));
            chk($sformatf("vec%0d.addr", i), 128'(amm_if.address), 128'(vecs[i].e_addr));
            chk($sformatf("vec%0d.bc", i), 128'(amm_if.burstcount), 128'(vecs[i].e_bc));
         end
      end

      // Read burst 8 with two stall cycles, then eight returned beats
      cycle(1'b1, 11'd8, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 31'h100, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("rd8.read_held", 128'(amm_if.read), 128'(1'b1));
      chk("rd8.addr", 128'(amm_if.address), 128'(31'h100));
      chk("rd8.bc", 128'(amm_if.burstcount), 128'(11'd8));
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("rd8.read_done", 128'(amm_if.read), 128'(1'b0));
      for (int k = 1; k <= 8; k++) begin
         cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
         chk($sformatf("rd8.busy%0d", k), 128'(trans_busy), 128'(1'b1));
      end
      idle();
      chk("rd8.busy_end", 128'(trans_busy), 128'(1'b0));
      chk("rd8.underflow", 128'(rd_underflow), 128'(1'b0));

      // Outstanding limit: 8 + 8 with a simultaneous return leaves 15 owed
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 31'h300, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("lim.first_free", 128'(trans_process), 128'(1'b0));
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 31'h340, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("lim.stall15", 128'(trans_process), 128'(1'b1));
      for (int k = 1; k <= 7; k++) begin
         cycle(1'b0, '0, '0, 1'b1, 1'b1, 31'h380, 1'b0, 1'b1);
         chk($sformatf("lim.stall_k%0d", k), 128'(trans_process), 128'(k < 7));
      end
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 31'h380, 1'b0, 1'b0);
      chk("lim.third_read", 128'(amm_if.read), 128'(1'b1));
      chk("lim.third_addr", 128'(amm_if.address), 128'(31'h380));
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("lim.full16", 128'(trans_process), 128'(1'b1));
      drain();

      // Burstcount 0 behaves as 1; stray return sets the sticky underflow
      cycle(1'b1, 11'd0, 32'hDEAD_0000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 31'h7, 1'b0, 1'b0);
      chk("bc0.burstcount", 128'(amm_if.burstcount), 128'(11'd1));
      chk("bc0.data", amm_if.writedata, rep(32'hDEAD_0000));
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("bc0.single_beat", 128'(amm_if.write), 128'(1'b0));
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("uf.set", 128'(rd_underflow), 128'(1'b1));
      idle();
      chk("uf.sticky", 128'(rd_underflow), 128'(1'b1));
      cycle(1'b1, 11'd2, 32'h1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("uf.cleared", 128'(rd_underflow), 128'(1'b0));

      // Reset in the middle of a 4-beat write, then restart from seed+0
      cycle(1'b1, 11'd4, 32'h5555_0000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 31'h80, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("rstw.beat2", amm_if.writedata, rep(32'h5555_0001));
      do_reset();
      chk("rstw.write", 128'(amm_if.write), 128'(1'b0));
      chk("rstw.busy", 128'(trans_busy), 128'(1'b0));
      chk("rstw.process", 128'(trans_process), 128'(1'b0));
      cycle(1'b1, 11'd4, 32'h5555_0000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 31'h90, 1'b0, 1'b0);
      chk("rstw.restart", amm_if.writedata, rep(32'h5555_0000));
      repeat (5) idle();

      // Random traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         logic st, v, ty, wt, dv;
         logic [10:0] bc;
         st = ($urandom_range(0, 39) == 0);
         bc = 11'($urandom_range(0, 9));
         v  = ($urandom_range(0, 2) != 0);
         ty = 1'($urandom_range(0, 1));
         wt = ($urandom_range(0, 3) == 0);
         dv = (m_pend != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
         cycle(st, bc, $urandom, v, ty, 31'($urandom), wt, dv);
      end
      drain();
      check_model();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
